// File: rtl/game_pkg.sv
// Shared game-level encodings: the game state seen by the scheduler and pixel_gen,
// and the laser scheduler's phase encoding.
package game_pkg;

    localparam logic [1:0] GAME_PRESS_START = 2'd0;
    localparam logic [1:0] GAME_PLAYING     = 2'd1;
    localparam logic [1:0] GAME_OVER        = 2'd2;
    localparam logic [1:0] GAME_IDLE        = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WARN,
        S_FIRE,
        S_COOL
    } sched_state_t;

endpackage

// File: rtl/enemy_laser_scheduler_if.sv
// Signal bundle between the game core and the enemy laser scheduler.
// The game core is the master; the scheduler is the slave.
interface enemy_laser_scheduler_if #(
    parameter int unsigned N_ENEMY = 8
);

    logic               tick;
    logic [1:0]         state;
    logic [N_ENEMY-1:0] enemy_alive;
    logic [N_ENEMY-1:0] fire_req;
    logic [N_ENEMY-1:0] enemy_waring_enable;
    logic [N_ENEMY-1:0] enemy_laser_enable;
    logic               busy;

    modport master (
        output tick, state, enemy_alive, fire_req,
        input  enemy_waring_enable, enemy_laser_enable, busy
    );

    modport slave (
        input  tick, state, enemy_alive, fire_req,
        output enemy_waring_enable, enemy_laser_enable, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request bit strictly after ptr,
// wrapping modulo N. Grant is zero when no request is set.
module rr_arbiter #(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    always_comb begin
        logic        found;
        int unsigned idx;
        found     = 1'b0;
        idx       = 0;
        grant     = '0;
        grant_idx = ptr;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!found && req[IDX_W'(idx)]) begin
                found                 = 1'b1;
                grant[IDX_W'(idx)]    = 1'b1;
                grant_idx             = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/enemy_laser_scheduler.sv
// Shares the single enemy-laser sprite among the enemy columns: round-robin grant,
// then warning, firing and cooldown phases counted in game ticks.
module enemy_laser_scheduler
    import game_pkg::*;
#(
    parameter int unsigned N_ENEMY    = 8,
    parameter int unsigned WARN_TICKS = 16,
    parameter int unsigned FIRE_TICKS = 32,
    parameter int unsigned COOL_TICKS = 8,
    parameter int unsigned CNT_W      = 6
) (
    input  logic                    clk,
    input  logic                    reset_n,
    enemy_laser_scheduler_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(N_ENEMY);

    sched_state_t       fsm_q, fsm_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [N_ENEMY-1:0] grant_q, grant_d;
    logic [N_ENEMY-1:0] cand;
    logic [N_ENEMY-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               granted_lost;

    always_comb begin
        cand = bus.fire_req & bus.enemy_alive;
    end

    rr_arbiter #(
        .N     (N_ENEMY),
        .IDX_W (IDX_W)
    ) u_arb (
        .req       (cand),
        .ptr       (ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q   <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= IDX_W'(N_ENEMY - 1);
            grant_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    // Game state outranks the phase machine; within a phase, losing the granted
    // enemy outranks the tick countdown.
    always_comb begin
        fsm_d        = fsm_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        granted_lost = (grant_q & bus.enemy_alive) == '0;
        case (bus.state)
            GAME_OVER: begin
            end
            GAME_PLAYING: begin
                case (fsm_q)
                    S_IDLE: begin
                        if (cand != '0) begin
                            grant_d = arb_grant;
                            ptr_d   = arb_idx;
                            cnt_d   = CNT_W'(WARN_TICKS);
                            fsm_d   = S_WARN;
                        end
                    end
                    S_WARN, S_FIRE: begin
                        if (granted_lost) begin
                            cnt_d = CNT_W'(COOL_TICKS);
                            fsm_d = S_COOL;
                        end else if (bus.tick) begin
                            if (cnt_q == CNT_W'(1)) begin
                                if (fsm_q == S_WARN) begin
                                    cnt_d = CNT_W'(FIRE_TICKS);
                                    fsm_d = S_FIRE;
                                end else begin
                                    cnt_d = CNT_W'(COOL_TICKS);
                                    fsm_d = S_COOL;
                                end
                            end else begin
                                cnt_d = cnt_q - CNT_W'(1);
                            end
                        end
                    end
                    S_COOL: begin
                        if (bus.tick) begin
                            if (cnt_q == CNT_W'(1)) begin
                                cnt_d = '0;
                                fsm_d = S_IDLE;
                            end else begin
                                cnt_d = cnt_q - CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        fsm_d = S_IDLE;
                    end
                endcase
            end
            default: begin
                fsm_d   = S_IDLE;
                cnt_d   = '0;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        bus.enemy_waring_enable = '0;
        bus.enemy_laser_enable  = '0;
        bus.busy                = fsm_q != S_IDLE;
        case (fsm_q)
            S_WARN:  bus.enemy_waring_enable = grant_q;
            S_FIRE:  bus.enemy_laser_enable  = grant_q;
            default: begin
            end
        endcase
    end

endmodule
